// File: rtl/fetch_decode_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_queue_if
// Purpose  : Handshake bundle between fetch, the IF->ID queue and decode.
//            Fetch side: flush, in_valid/in_ready, in_pc/inst/exc/cause.
//            Decode side: out_valid/out_ready, out_pc/inst/exc/cause.
//            Also carries the queue occupancy (count).
// Modports : master - the fetch/decode environment around the queue
//            slave  - the queue itself
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_decode_queue_if #(
   parameter int PC_W    = 32,
   parameter int INST_W  = 32,
   parameter int EXC_W   = 5,
   parameter int CAUSE_W = 35,
   parameter int DEPTH   = 4
) ();
   logic                         flush;
   logic                         in_valid;
   logic                         in_ready;
   logic [PC_W-1:0]              in_pc;
   logic [INST_W-1:0]            in_inst;
   logic [EXC_W-1:0]             in_exc;
   logic [CAUSE_W-1:0]           in_cause;
   logic                         out_valid;
   logic                         out_ready;
   logic [PC_W-1:0]              out_pc;
   logic [INST_W-1:0]            out_inst;
   logic [EXC_W-1:0]             out_exc;
   logic [CAUSE_W-1:0]           out_cause;
   logic [$clog2(DEPTH+1)-1:0]   count;

   modport master (
      output flush, in_valid, in_pc, in_inst, in_exc, in_cause, out_ready,
      input  in_ready, out_valid, out_pc, out_inst, out_exc, out_cause, count
   );

   modport slave (
      input  flush, in_valid, in_pc, in_inst, in_exc, in_cause, out_ready,
      output in_ready, out_valid, out_pc, out_inst, out_exc, out_cause, count
   );
endinterface
`default_nettype wire

// File: rtl/fetch_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_queue
// Purpose  : First-word-fall-through FIFO of fetch bundles
//            {pc, inst, exc, cause} decoupling IF from ID. Fetch can run
//            ahead while decode stalls; a single flush empties the queue.
// Ports    : clk  - clock
//            rst  - synchronous active-high reset
//            bus  - fetch_decode_queue_if.slave (handshakes, data, count)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_decode_queue #(
   parameter int                  PC_W      = 32,
   parameter int                  INST_W    = 32,
   parameter int                  EXC_W     = 5,
   parameter int                  CAUSE_W   = 35,
   parameter int                  DEPTH     = 4,
   parameter logic [PC_W-1:0]     BUBBLE_PC = 32'h100,
   parameter logic [CAUSE_W-1:0]  CAUSE_NOP = '0
) (
   input  wire logic             clk,
   input  wire logic             rst,
   fetch_decode_queue_if.slave   bus
);
   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = $clog2(DEPTH + 1);
   localparam int c_ENT_W = PC_W + INST_W + EXC_W + CAUSE_W;

   logic [c_ENT_W-1:0] r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;

   logic               w_full;
   logic               w_nonempty;
   logic               w_push;
   logic               w_pop;
   logic [c_ENT_W-1:0] w_head;

   // Handshake outputs come only from the registered count, so neither
   // in_valid nor out_ready can form a combinational path back out.
   assign w_full     = (r_count == c_CNT_W'(DEPTH));
   assign w_nonempty = (r_count != '0);
   assign w_push     = bus.in_valid  & ~w_full     & ~bus.flush;
   assign w_pop      = bus.out_ready & w_nonempty  & ~bus.flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (bus.flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      end
   end

   // Storage is not reset; the pointers/count alone define what is valid.
   // w_push is already blocked by flush, and rst leaves stale data harmless.
   always_ff @(posedge clk) begin
      if (w_push && !rst) begin
         r_mem[r_wr_ptr] <= {bus.in_pc, bus.in_inst, bus.in_exc, bus.in_cause};
      end
   end

   assign w_head = r_mem[r_rd_ptr];

   assign bus.in_ready  = ~w_full;
   assign bus.out_valid = w_nonempty;
   assign bus.count     = r_count;

   // Head fields, or bubble values while empty.
   assign bus.out_pc    = w_nonempty ? w_head[c_ENT_W-1 -: PC_W]                    : BUBBLE_PC;
   assign bus.out_inst  = w_nonempty ? w_head[EXC_W+CAUSE_W+INST_W-1 -: INST_W]     : '0;
   assign bus.out_exc   = w_nonempty ? w_head[CAUSE_W+EXC_W-1 -: EXC_W]             : '0;
   assign bus.out_cause = w_nonempty ? w_head[CAUSE_W-1:0]                          : CAUSE_NOP;
endmodule
`default_nettype wire
